pixel_swizzle_stream: RTL and testbench

Parametrised, pipelined channel swizzler for the streaming pixel path, placed between the frame-buffer read port and the VGA output formatter. Each output channel is independently driven from any input channel, forced to zero or full-scale, and optionally inverted. Configuration is double-buffered and takes effect only at a frame boundary, so a mid-frame write never tears an image. The data path has valid/ready flow control and supports back-pressure.

---
 rtl/pixel_pkg.sv | 22 ++
 rtl/swz_channel_sel.sv | 22 ++
 rtl/pixel_swizzle_stream.sv | 89 ++++++++
 tb/tb_pixel_swizzle_stream.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared defaults, select encodings and identity configuration for the pixel swizzler
package pixel_pkg;
  localparam int CH_W_DEF = 4;
  localparam int N_CH_DEF = 3;
  typedef struct packed {
    logic zero;
    logic ones;
    logic inv;
  } ch_ctl_t;
  function automatic int sel_zero(input int n);
    return n;
  endfunction
  function automatic int sel_ones(input int n);
    return n + 1;
  endfunction
  function automatic logic [63:0] identity_cfg(input int n, input int sw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r |= 64'(i) << ((n - 1 - i) * (sw + 1));
    return r;
  endfunction
endpackage

// File: rtl/swz_channel_sel.sv
// swz_channel_sel: per-output-channel source select and constant/invert decode
module swz_channel_sel
  import pixel_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = $clog2(N_CH + 2)
) (
  input  logic [N_CH*CH_W-1:0] pix_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic                 inv_i,
  output logic [CH_W-1:0]      ch_o,
  output ch_ctl_t              ctl_o
);
  always_comb begin
    ch_o = '0;
    for (int j = 0; j < N_CH; j++) if (sel_i == SEL_W'(j)) ch_o = pix_i[(N_CH-1-j)*CH_W +: CH_W];
    ctl_o.ones = sel_i == SEL_W'(sel_ones(N_CH));
    ctl_o.zero = sel_i == SEL_W'(sel_zero(N_CH)) || sel_i > SEL_W'(sel_ones(N_CH));
    ctl_o.inv  = inv_i;
  end
endmodule

// File: rtl/pixel_swizzle_stream.sv
// pixel_swizzle_stream: two-stage channel swizzler with frame-aligned double-buffered configuration
module pixel_swizzle_stream
  import pixel_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = $clog2(N_CH + 2),
  parameter int CFG_W = N_CH * (SEL_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 cfg_pending,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N_CH*CH_W-1:0] s_data,
  input  logic                 s_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N_CH*CH_W-1:0] m_data,
  output logic                 m_sof
);
  localparam logic [63:0] ID_W = identity_cfg(N_CH, SEL_W);
  localparam logic [CFG_W-1:0] ID_CFG = ID_W[CFG_W-1:0];
  logic [CFG_W-1:0] act_q, act_d, pcfg_q, pcfg_d, beat_cfg;
  logic pend_q, pend_d, v1_q, v1_d, v2_q, v2_d, sof1_q, sof1_d, sof2_q, sof2_d;
  logic acc, sof_acc, adv2;
  logic [N_CH*CH_W-1:0] sel_pix, d1_q, d1_d, d2_q, d2_d, out2;
  ch_ctl_t [N_CH-1:0] ctl_s, ctl1_q, ctl1_d;
  assign adv2 = !v2_q || m_ready;
  assign s_ready = !v1_q || adv2;
  assign cfg_pending = pend_q;
  assign m_valid = v2_q;
  assign m_data = d2_q;
  assign m_sof = sof2_q;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    swz_channel_sel #(.CH_W(CH_W), .N_CH(N_CH), .SEL_W(SEL_W)) u_sel (
      .pix_i(s_data),
      .sel_i(beat_cfg[(N_CH-1-c)*(SEL_W+1) +: SEL_W]),
      .inv_i(beat_cfg[(N_CH-1-c)*(SEL_W+1) + SEL_W]),
      .ch_o (sel_pix[(N_CH-1-c)*CH_W +: CH_W]),
      .ctl_o(ctl_s[c])
    );
    assign out2[(N_CH-1-c)*CH_W +: CH_W] = {CH_W{ctl1_q[c].inv}} ^
      (ctl1_q[c].ones ? {CH_W{1'b1}} : ctl1_q[c].zero ? {CH_W{1'b0}} : d1_q[(N_CH-1-c)*CH_W +: CH_W]);
  end
  // A write coinciding with an accepted SOF bypasses the pending buffer and lands on that beat
  always_comb begin
    acc      = s_valid && s_ready;
    sof_acc  = acc && s_sof;
    beat_cfg = sof_acc && cfg_valid ? cfg_data : sof_acc && pend_q ? pcfg_q : act_q;
    act_d    = beat_cfg;
    pcfg_d   = cfg_valid ? cfg_data : pcfg_q;
    pend_d   = !sof_acc && (cfg_valid || pend_q);
    v1_d     = s_ready ? s_valid : v1_q;
    d1_d     = acc ? sel_pix : d1_q;
    ctl1_d   = acc ? ctl_s : ctl1_q;
    sof1_d   = acc ? s_sof : sof1_q;
    v2_d     = adv2 ? v1_q : v2_q;
    d2_d     = adv2 && v1_q ? out2 : d2_q;
    sof2_d   = adv2 && v1_q ? sof1_q : sof2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= ID_CFG;
      pcfg_q <= ID_CFG;
      pend_q <= 1'b0;
      v1_q   <= 1'b0;
      d1_q   <= '0;
      ctl1_q <= '0;
      sof1_q <= 1'b0;
      v2_q   <= 1'b0;
      d2_q   <= '0;
      sof2_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      pcfg_q <= pcfg_d;
      pend_q <= pend_d;
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      ctl1_q <= ctl1_d;
      sof1_q <= sof1_d;
      v2_q   <= v2_d;
      d2_q   <= d2_d;
      sof2_q <= sof2_d;
    end
  end
endmodule

// File: tb/tb_pixel_swizzle_stream.sv
// tb_pixel_swizzle_stream: scoreboard bench with directed swizzle vectors and random back-pressure
module tb_pixel_swizzle_stream;
  logic clk = 0, rst_n = 0, cfg_valid = 0, s_valid = 0, s_sof = 0, m_ready = 1;
  logic [11:0] cfg_data = 0, s_data = 0;
  logic cfg_pending, s_ready, m_valid, m_sof;
  logic [11:0] m_data;
  int errors = 0, checks = 0;
  logic [12:0] q[$];
  logic held = 0;
  logic [12:0] hv = 0;

  pixel_swizzle_stream dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_pending(cfg_pending), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (!rst_n) held = 0;
    else begin
      if (held) chk("stall_hold", {19'd0, m_sof, m_data}, {19'd0, hv});
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h expected no beat", {m_sof, m_data});
        end else chk("beat", {19'd0, m_sof, m_data}, {19'd0, q.pop_front()});
      end
      held = m_valid && !m_ready;
      hv = {m_sof, m_data};
    end
  end

  task automatic send(input logic [11:0] d, input logic sof, input logic [11:0] e, input int stall,
                      input logic wc = 0, input logic [11:0] c = 0);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    s_valid = 1; s_data = d; s_sof = sof; cfg_valid = wc; cfg_data = c;
    while (!acc && n < 100) begin
      m_ready = ($urandom_range(99) >= stall);
      #4;
      acc = s_ready;
      @(posedge clk);
      if (acc) q.push_back({sof, e});
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %h", d);
    end
    s_valid = 0; s_sof = 0; cfg_valid = 0;
  endtask

  task automatic wr(input logic [11:0] c);
    cfg_valid = 1; cfg_data = c;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic idle(input int n);
    m_ready = 1; s_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [11:0] d;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sof", m_sof, 0);
    chk("rst_cfg_pending", cfg_pending, 0);
    rst_n = 1;
    @(negedge clk);
    send(12'hA5C, 1, 12'hA5C, 0);
    chk("latency_early", m_valid, 0);
    send(12'h123, 0, 12'h123, 0);
    chk("latency_valid", m_valid, 1);
    idle(4);
    wr(12'hA03);
    chk("pending_set", cfg_pending, 1);
    send(12'hA5C, 0, 12'hA5C, 0);
    send(12'hA5C, 1, 12'h3A0, 0);
    chk("pending_clr", cfg_pending, 0);
    send(12'h123, 0, 12'hC10, 0);
    idle(4);
    send(12'h5A5, 1, 12'hFFF, 0, 1, 12'h444);
    chk("same_cycle_pending", cfg_pending, 0);
    send(12'h123, 0, 12'hFFF, 0);
    idle(4);
    wr(12'hA03);
    wr(12'h89A);
    chk("b2b_pending", cfg_pending, 1);
    send(12'hA5C, 1, 12'h5A3, 0);
    for (int i = 0; i < 1000; i++) begin
      d = 12'($urandom);
      send(d, i % 64 == 0, ~d, 40);
    end
    idle(8);
    chk("drain_empty", q.size(), 0);
    send(12'h111, 0, 12'hEEE, 100);
    send(12'h222, 0, 12'hDDD, 100);
    wr(12'h444);
    chk("full_pending", cfg_pending, 1);
    chk("full_m_valid", m_valid, 1);
    rst_n = 0;
    q.delete();
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_pending", cfg_pending, 0);
    chk("mid_rst_m_data", m_data, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(12'h123, 1, 12'h123, 0);
    idle(6);
    chk("final_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
